// File: rtl/approx_mul_pattern_gen.sv
// Exhaustive stimulus generator / response collector for a 2x2 approximate
// multiplier error detector. Walks all 16 operand patterns p = {b1,b0,a1,a0},
// waits SETTLE cycles after driving each, samples the detector's error flag
// and accumulates error count, per-pattern fail bitmap and first failure.
//
// Handshake: start is a request accepted only in IDLE/DONE (no ready needed);
// pat_valid qualifies the operand bits, and err_in is a combinational response
// that is only consumed in SAMPLE. abort wins over sampling in a busy state.
module approx_mul_pattern_gen #(
   parameter int SETTLE = 1,
   parameter int PAT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             a0,
   output logic             a1,
   output logic             b0,
   output logic             b1,
   output logic             pat_valid,
   input  logic             err_in,
   output logic             busy,
   output logic             done,
   output logic [4:0]       err_count,
   output logic [15:0]      fail_map,
   output logic [3:0]       first_fail_pat,
   output logic             first_fail_valid,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   localparam bit             HAS_WAIT    = (SETTLE > 0);
   localparam logic [3:0]     SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic [PAT_W-1:0] PAT_LAST  = {PAT_W{1'b1}};

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   p_q, p_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [4:0]         err_count_q, err_count_d;
   logic [15:0]        fail_map_q, fail_map_d;
   logic [3:0]         ff_pat_q, ff_pat_d;
   logic               ff_valid_q, ff_valid_d;
   logic               start_sweep;

   // A sweep can only be launched from a non-busy state.
   assign start_sweep = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort returns any busy state to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = S_DRIVE;
         end
         S_DRIVE: begin
            if (abort)         state_d = S_IDLE;
            else if (HAS_WAIT) state_d = S_WAIT;
            else               state_d = S_SAMPLE;
         end
         S_WAIT: begin
            if (abort)                    state_d = S_IDLE;
            else if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (abort)                state_d = S_IDLE;
            else if (p_q == PAT_LAST) state_d = S_DONE;
            else                      state_d = S_DRIVE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: busy and pat_valid cover the three pattern-driving states.
   always_comb begin
      busy        = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
      pat_valid   = busy;
      done        = (state_q == S_DONE);
      dbg_state_o = state_q;
   end

   // Datapath next-state: pattern index, settle counter and result accumulators.
   always_comb begin
      p_d         = p_q;
      cnt_d       = cnt_q;
      err_count_d = err_count_q;
      fail_map_d  = fail_map_q;
      ff_pat_d    = ff_pat_q;
      ff_valid_d  = ff_valid_q;
      if (start_sweep) begin
         p_d         = '0;
         cnt_d       = '0;
         err_count_d = '0;
         fail_map_d  = '0;
         ff_pat_d    = '0;
         ff_valid_d  = 1'b0;
      end else if (state_q == S_DRIVE) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + 4'd1;
      end else if ((state_q == S_SAMPLE) && !abort) begin
         if (err_in) begin
            fail_map_d  = fail_map_q | (16'd1 << p_q);
            err_count_d = err_count_q + 5'd1;
            if (!ff_valid_q) begin
               ff_pat_d   = p_q;
               ff_valid_d = 1'b1;
            end
         end
         // p stays at the last pattern so DONE keeps driving 4'b1111.
         if (p_q != PAT_LAST) p_d = p_q + 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         cnt_q       <= '0;
         err_count_q <= '0;
         fail_map_q  <= '0;
         ff_pat_q    <= '0;
         ff_valid_q  <= 1'b0;
      end else begin
         p_q         <= p_d;
         cnt_q       <= cnt_d;
         err_count_q <= err_count_d;
         fail_map_q  <= fail_map_d;
         ff_pat_q    <= ff_pat_d;
         ff_valid_q  <= ff_valid_d;
      end
   end

   assign {b1, b0, a1, a0}  = p_q;
   assign err_count         = err_count_q;
   assign fail_map          = fail_map_q;
   assign first_fail_pat    = ff_pat_q;
   assign first_fail_valid  = ff_valid_q;

endmodule
